// File: rtl/vram_scan_pkg.sv
// Shared types and widths for the VRAM scan-out reader (port B of the 16-bit x 8K GPU VRAM).
package vram_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } scan_state_t;

    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 4;
    localparam int VRAM_AW      = 13;
    localparam int VRAM_DW      = 16;

endpackage

// File: rtl/vram_scan_reader_if.sv
// VRAM port-B bus plus the pixel valid/ready stream; master is the scan reader.
interface vram_scan_reader_if;
    import vram_scan_pkg::*;

    logic [VRAM_AW-1:0] adb;
    logic               ceb;
    logic               oceb;
    logic               wreb;
    logic [VRAM_DW-1:0] doutb;

    logic               pix_valid;
    logic               pix_ready;
    logic [PIX_W-1:0]   pix_data;
    logic               pix_sof;
    logic               pix_eol;

    modport master (
        output adb, ceb, oceb, wreb, pix_valid, pix_data, pix_sof, pix_eol,
        input  doutb, pix_ready
    );

    modport slave (
        input  adb, ceb, oceb, wreb, pix_valid, pix_data, pix_sof, pix_eol,
        output doutb, pix_ready
    );

endinterface

// File: rtl/vram_scan_reader_fifo.sv
// Single-clock word FIFO for read prefetch; power-of-2 depth, flush clears it in one cycle.
module scan_word_fifo #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign count = cnt;
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/vram_scan_reader.sv
// Streams the framebuffer out of VRAM port B and unpacks words into 4bpp pixels.
// Optional VRAM_SCAN_LINE_DOUBLE_EN: every line is fetched and emitted twice.
module vram_scan_reader
    import vram_scan_pkg::*;
#(
    parameter logic [VRAM_AW-1:0] BASE_ADDR  = 13'h0000,
    parameter int                 H_WORDS    = 40,
    parameter int                 V_LINES    = 120,
    parameter int                 FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    vram_scan_reader_if.master   bus,
    output logic                 underrun,
    output logic                 busy
);

    localparam int FAW = $clog2(FIFO_DEPTH);
`ifdef VRAM_SCAN_LINE_DOUBLE_EN
    localparam int LINE_PASSES = 2;
`else
    localparam int LINE_PASSES = 1;
`endif
    localparam int                 FRAME_LINES = V_LINES * LINE_PASSES;
    localparam logic [VRAM_AW-1:0] LAST_WORD   = VRAM_AW'(H_WORDS * V_LINES - 1);
    localparam logic [15:0]        LAST_PIX    = 16'(H_WORDS * PIX_PER_WORD - 1);
    localparam logic [15:0]        LAST_LINE   = 16'(FRAME_LINES - 1);

    scan_state_t        state;
    scan_state_t        state_nx;
    logic [VRAM_AW-1:0] word_idx;
    logic               fetch_at_end;
    logic               issue;
    logic               credit_ok;
    logic               rd_pending;
    logic               rd_epoch;
    logic               epoch;
    logic [1:0]         nib;
    logic [15:0]        ocol;
    logic [15:0]        oline;
    logic               hs;
    logic               last_hs;
    logic               frame_done;

    logic               fifo_push;
    logic               fifo_pop;
    logic [VRAM_DW-1:0] fifo_head;
    logic [FAW:0]       fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    scan_word_fifo #(.DEPTH(FIFO_DEPTH), .DW(VRAM_DW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (frame_start),
        .push  (fifo_push),
        .wdata (bus.doutb),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy (stored words + read in flight) must stay below FIFO_DEPTH.
    assign credit_ok = !fifo_full &&
                       !((fifo_count == (FAW+1)'(FIFO_DEPTH - 1)) && rd_pending);

`ifdef VRAM_SCAN_LINE_DOUBLE_EN
    localparam logic [VRAM_AW-1:0] LAST_COL = VRAM_AW'(H_WORDS - 1);
    logic [VRAM_AW-1:0] fcol;
    logic               pass;

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            word_idx <= '0;
            fcol     <= '0;
            pass     <= 1'b0;
        end else if (issue) begin
            if (fcol == LAST_COL) begin
                fcol <= '0;
                pass <= !pass;
                // First pass rewinds to the start of the same line.
                word_idx <= pass ? word_idx + VRAM_AW'(1) : word_idx - LAST_COL;
            end else begin
                fcol     <= fcol + VRAM_AW'(1);
                word_idx <= word_idx + VRAM_AW'(1);
            end
        end
    end

    assign fetch_at_end = (word_idx == LAST_WORD) && pass;
`else
    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            word_idx <= '0;
        end else if (issue) begin
            word_idx <= word_idx + VRAM_AW'(1);
        end
    end

    assign fetch_at_end = (word_idx == LAST_WORD);
`endif

    // Epoch tag guards against a pre-restart read landing in the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_epoch   <= 1'b0;
            epoch      <= 1'b0;
        end else begin
            rd_pending <= issue;
            rd_epoch   <= epoch;
            if (frame_start) epoch <= !epoch;
        end
    end

    assign fifo_push = rd_pending && (rd_epoch == epoch);

    assign bus.ceb  = issue;
    assign bus.adb  = issue ? (BASE_ADDR + word_idx) : '0;
    assign bus.oceb = 1'b1;
    assign bus.wreb = 1'b0;

    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_head[{nib, 2'b00} +: PIX_W];
    assign bus.pix_sof   = bus.pix_valid && (ocol == '0) && (oline == '0);
    assign bus.pix_eol   = bus.pix_valid && (ocol == LAST_PIX);

    assign hs       = bus.pix_valid && bus.pix_ready;
    assign fifo_pop = hs && (nib == 2'd3);
    assign last_hs  = hs && (ocol == LAST_PIX) && (oline == LAST_LINE);

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            nib   <= '0;
            ocol  <= '0;
            oline <= '0;
        end else if (hs) begin
            nib <= nib + 2'd1;
            if (ocol == LAST_PIX) begin
                ocol  <= '0;
                oline <= oline + 16'd1;
            end else begin
                ocol <= ocol + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: ;
            FETCH: begin
                issue = credit_ok && !frame_start;
                if (issue && fetch_at_end) state_nx = DRAIN;
            end
            DRAIN: begin
                if (last_hs && !rd_pending) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (frame_start) state_nx = FETCH;
    end

    always_comb begin
        busy     = frame_start || ((state != IDLE) && !frame_done);
        underrun = (state == FETCH) && bus.pix_ready && !bus.pix_valid;
    end

endmodule

// File: tb/tb_vram_scan_reader.sv
// Scoreboard bench for vram_scan_reader: reference frame model, VRAM model, stall/restart/reset scenarios.
module tb_vram_scan_reader;
    import vram_scan_pkg::*;

    localparam logic [VRAM_AW-1:0] BASE = 13'h1FF0;
    localparam int H     = 40;
    localparam int V     = 120;
    localparam int DEPTH = 8;
`ifdef VRAM_SCAN_LINE_DOUBLE_EN
    localparam int PASSES    = 2;
    localparam int STALL_PCT = 10;
`else
    localparam int PASSES    = 1;
    localparam int STALL_PCT = 30;
`endif
    localparam int LINE_PIX    = H * PIX_PER_WORD;
    localparam int FRAME_LINES = V * PASSES;
    localparam int FRAME_PIX   = LINE_PIX * FRAME_LINES;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
    } pix_t;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic underrun;
    logic busy;

    vram_scan_reader_if bus();

    vram_scan_reader #(
        .BASE_ADDR  (BASE),
        .H_WORDS    (H),
        .V_LINES    (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bus         (bus),
        .underrun    (underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [VRAM_DW-1:0] mem [8192];
    always @(posedge clk) if (bus.ceb) bus.doutb <= mem[bus.adb];

    pix_t               exp_q[$];
    logic [VRAM_AW-1:0] addr_q[$];
    pix_t               exp_pix;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   acc_frame = 0, eol_cnt = 0, sof_cnt = 0, issued = 0, popped = 0;
    logic got_first = 1'b0, prev_stall = 1'b0, rand_mode = 1'b0;
    logic [PIX_W-1:0] prev_data;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s: event not expected or not seen in time (t=%0t)", name, $time);
    endtask

    // Expected frame: lines in order (each repeated when line doubling), words in order, low nibble first.
    task automatic load_frame();
        exp_q.delete();
        addr_q.delete();
        for (int ln = 0; ln < FRAME_LINES; ln++) begin
            for (int w = 0; w < H; w++) begin
                logic [VRAM_AW-1:0] a;
                logic [VRAM_DW-1:0] word;
                a    = VRAM_AW'(int'(BASE) + (ln / PASSES) * H + w);
                word = mem[a];
                addr_q.push_back(a);
                for (int n = 0; n < PIX_PER_WORD; n++) begin
                    pix_t p;
                    p.data = PIX_W'(word >> (PIX_W * n));
                    p.sof  = (ln == 0) && (w == 0) && (n == 0);
                    p.eol  = (w == H - 1) && (n == PIX_PER_WORD - 1);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset || frame_start) begin
            issued = 0; popped = 0; acc_frame = 0; eol_cnt = 0; sof_cnt = 0;
            got_first = 1'b0; prev_stall = 1'b0;
        end else begin
            if (bus.ceb) begin
                check_eq("credit", 32'(issued - popped < DEPTH), 32'd1);
                if (addr_q.size() == 0) fail_now("extra_read");
                else check_eq("adb", 32'(bus.adb), 32'(addr_q.pop_front()));
                issued++;
            end
            if (got_first) check_eq("underrun", 32'(underrun), 32'd0);
            if (prev_stall) begin
                check_eq("stall_valid", 32'(bus.pix_valid), 32'd1);
                check_eq("stall_data", 32'(bus.pix_data), 32'(prev_data));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_pixel");
                end else begin
                    exp_pix = exp_q.pop_front();
                    check_eq("pix_data", 32'(bus.pix_data), 32'(exp_pix.data));
                    check_eq("pix_sof", 32'(bus.pix_sof), 32'(exp_pix.sof));
                    check_eq("pix_eol", 32'(bus.pix_eol), 32'(exp_pix.eol));
                    if (exp_q.size() != 0) check_eq("busy_mid", 32'(busy), 32'd1);
                end
                acc_frame++;
                if (acc_frame % PIX_PER_WORD == 0) popped++;
                if (bus.pix_eol) eol_cnt++;
                if (bus.pix_sof) sof_cnt++;
            end
            if (bus.pix_valid) got_first = 1'b1;
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_data  = bus.pix_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        if (rand_mode) bus.pix_ready = ($urandom_range(0, 99) >= STALL_PCT);
    endtask

    task automatic wait_frame_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_now("frame_timeout");
        check_eq("frame_pixels", 32'(acc_frame), 32'(FRAME_PIX));
        check_eq("frame_eol", 32'(eol_cnt), 32'(FRAME_LINES));
        check_eq("frame_sof", 32'(sof_cnt), 32'd1);
        check_eq("reads_left", 32'(addr_q.size()), 32'd0);
        check_eq("end_valid", 32'(bus.pix_valid), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 8192; k++) mem[k] = 16'h3210 ^ 16'(k);
        reset         = 1'b1;
        frame_start   = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) step();
        check_eq("rst_adb", 32'(bus.adb), 32'd0);
        check_eq("rst_ceb", 32'(bus.ceb), 32'd0);
        check_eq("rst_valid", 32'(bus.pix_valid), 32'd0);
        check_eq("rst_sof", 32'(bus.pix_sof), 32'd0);
        check_eq("rst_eol", 32'(bus.pix_eol), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("oceb", 32'(bus.oceb), 32'd1);
        check_eq("wreb", 32'(bus.wreb), 32'd0);
        reset = 1'b0;
        step();

        // Frame aborted by reset mid-fetch.
        frame_start = 1'b1;
        load_frame();
        n = 0;
        while (acc_frame < 200 && n < 2000) begin step(); n++; end
        if (n >= 2000) fail_now("abort_progress");
        reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        step();
        reset = 1'b0;
        check_eq("abort_valid", 32'(bus.pix_valid), 32'd0);
        check_eq("abort_ceb", 32'(bus.ceb), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (4) step();
        check_eq("idle_ceb", 32'(bus.ceb), 32'd0);

        // Clean full frame, consumer always ready.
        frame_start = 1'b1;
        load_frame();
        wait_frame_done(FRAME_PIX + 200);

        // Random stalls, restart coinciding with a handshake, then a full stalled frame.
        rand_mode   = 1'b1;
        frame_start = 1'b1;
        load_frame();
        n = 0;
        while (!(acc_frame >= 500 && bus.pix_valid) && n < 5000) begin step(); n++; end
        if (n >= 5000) fail_now("restart_point");
        bus.pix_ready = 1'b1;
        frame_start   = 1'b1;
        load_frame();
        wait_frame_done(FRAME_PIX * 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/vram_scan_reader.md
Name: vram_scan_reader

Overview:
- Read-side master for port B of the 16-bit x 8K GPU VRAM.
- Each frame, streams the framebuffer out of VRAM in address order and unpacks each word into 4bpp pixels.
- Hands pixels to the video timing/palette stage over a valid/ready stream.
- Prefetches through a small word FIFO so VRAM read latency never stalls the pixel stream.

Parameters:
- BASE_ADDR, 13'h0000, first VRAM word of the framebuffer.
- H_WORDS, 40, words per line (4 pixels each, so 160 px).
- V_LINES, 120, lines per frame.
- FIFO_DEPTH, 8, prefetch FIFO depth in words (power of 2, at least 4).

Ports:
- clk  in  1  system clock; also drives the VRAM port-B clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle pulse that (re)starts a frame fetch.
- adb  out  13  VRAM port-B word address.
- ceb  out  1  VRAM port-B clock enable (read strobe).
- oceb  out  1  VRAM port-B output clock enable; constant 1.
- wreb  out  1  VRAM port-B write enable; constant 0.
- doutb  in  16  VRAM port-B read data.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  consumer accepts the pixel.
- pix_data  out  4  pixel palette index.
- pix_sof  out  1  marks the first pixel of the frame (qualified by pix_valid).
- pix_eol  out  1  marks the last pixel of a line (qualified by pix_valid).
- underrun  out  1  one-cycle pulse: consumer ready, FIFO empty, frame active.
- busy  out  1  high from frame_start until the last pixel of the frame is accepted.

Behaviour:
- Reset values:
  - adb=0, ceb=0, pix_valid=0, pix_sof=0, pix_eol=0, underrun=0, busy=0.
  - FIFO empty, all counters 0, FSM in IDLE.
  - Reset mid-frame aborts the frame immediately.
- VRAM timing:
  - ceb=1 in cycle N with adb=A; doutb holds word A in cycle N+1 and is written into the FIFO then.
  - Exactly 1 cycle latency, at most one read in flight per cycle.
- FSM:
  - IDLE: frame_start goes to FETCH. The word counter, line counter, address (BASE_ADDR) and pixel counters are cleared.
  - FETCH: issues a read (ceb=1) when fifo_count + inflight < FIFO_DEPTH.
    - adb = BASE_ADDR + word_idx, modulo 8192; the address wraps silently past 13'h1FFF.
    - When the read of word H_WORDS*V_LINES-1 issues, the FSM goes to DRAIN.
  - DRAIN: no reads issue. Returns to IDLE when the FIFO is empty, nothing is in flight and the last pixel has been accepted. busy falls in that same cycle.
- frame_start in any state, including same-cycle with a handshake:
  - The restart wins and the FIFO is flushed.
  - Data of a read in flight is discarded (an epoch flag is tagged at issue).
  - The FSM goes to FETCH with counters reset.
- Unpack:
  - The head word is shown nibble by nibble: bits [3:0] first, [15:12] last.
  - A pixel transfers when pix_valid && pix_ready.
  - The FIFO pops after the 4th nibble is accepted.
  - pix_data and pix_valid stay stable while pix_valid=1 and pix_ready=0.
- Markers:
  - pix_eol=1 on pixel index H_WORDS*4-1 of each line.
  - pix_sof=1 on pixel 0 of line 0.
- underrun: pulses when pix_ready=1, pix_valid=0 and the FSM is in FETCH. No data is skipped; the stream resumes where it stopped.
- Full FIFO: ceb=0 (no read issues) until a pop frees a credit. A pop and an issue in the same cycle are allowed.
- Throughput: sustains 1 pixel per cycle, since the consumer takes 4 cycles per word and reads need 1.

Optional Feature:
- Macro: VRAM_SCAN_LINE_DOUBLE_EN.
- With the macro defined:
  - Each line is fetched twice: after the first pass of a line, word_idx rewinds to the start of that line.
  - The frame outputs 2*V_LINES lines; pix_eol fires on both passes.
  - DRAIN is entered after the second pass of the last line.
- Without the macro: each line is fetched once, V_LINES lines per frame, and there is no line-pass logic.

Decomposition:
- Package vram_scan_pkg holds:
  - state enum {IDLE, FETCH, DRAIN};
  - PIX_PER_WORD=4, PIX_W=4, VRAM_AW=13, VRAM_DW=16.
- Sub-module scan_word_fifo:
  - synchronous single-clock FIFO, parameterised by depth;
  - exposes count, full, empty; flush input driven by frame_start.

Test Plan:
1. Reset, then frame_start with pix_ready=1 and VRAM preloaded with word k = {4'h3,4'h2,4'h1,4'h0} ^ k. Expect pixels 0,1,2,3 in order for word 0; pix_sof on pixel 0 only; pix_eol on pixels 159, 319, and so on; 19200 pixels total; busy falls after the last one; underrun never pulses after the first word arrives.
2. pix_ready toggled at random at 30% duty. Expect an identical pixel sequence, pix_data stable while stalled, and ceb never high when fifo_count + inflight = FIFO_DEPTH.
3. BASE_ADDR=13'h1FF0. Expect adb to wrap from 1FFF to 0000 with the data sequence continuous.
4. frame_start pulse at pixel 500 in the same cycle as a handshake. Expect the next accepted pixel to be word 0 nibble 0 with pix_sof=1; the stale in-flight word never appears.
5. reset asserted mid-FETCH. Next cycle: pix_valid=0, ceb=0, busy=0. A following frame_start produces a clean frame.
6. With VRAM_SCAN_LINE_DOUBLE_EN defined: the adb sequence is 0..39, 0..39, 40..79, 40..79, and so on; 240 pix_eol pulses per frame.
